// File: rtl/uart_time_sender.sv
// Sends a snapshot of hour/min/sec/cent as "HH:MM:SS.CC" (plus optional CR LF)
// one byte at a time through a UART transmitter with a start/busy handshake.
module uart_time_sender #(
   parameter int SEND_CRLF = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_req,
   input  logic [4:0] hour,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [6:0] cent,
   input  logic       tx_busy,
   output logic       start_trigger,
   output logic [7:0] tx_data,
   output logic       sender_busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam logic [3:0] LAST_IDX = (SEND_CRLF != 0) ? 4'd12 : 4'd10;

   logic [1:0] state;
   logic [3:0] idx;
   logic [4:0] hour_s;
   logic [5:0] min_s;
   logic [5:0] sec_s;
   logic [6:0] cent_s;
   logic [7:0] cur_byte;

   // Fields above 99 saturate so the message always stays two digits wide.
   function automatic logic [6:0] clamp99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [7:0] tens_char(input logic [6:0] v);
      logic [6:0] q;
      q = clamp99(v) / 7'd10;
      return 8'h30 + {1'b0, q};
   endfunction

   function automatic logic [7:0] ones_char(input logic [6:0] v);
      logic [6:0] r;
      r = clamp99(v) % 7'd10;
      return 8'h30 + {1'b0, r};
   endfunction

   always_comb begin
      // NOTE: default first so every path assigns cur_byte and no latch is inferred.
      cur_byte = 8'h00;
      case (idx)
         4'd0:    cur_byte = tens_char({2'b00, hour_s});
         4'd1:    cur_byte = ones_char({2'b00, hour_s});
         4'd2:    cur_byte = 8'h3A;
         4'd3:    cur_byte = tens_char({1'b0, min_s});
         4'd4:    cur_byte = ones_char({1'b0, min_s});
         4'd5:    cur_byte = 8'h3A;
         4'd6:    cur_byte = tens_char({1'b0, sec_s});
         4'd7:    cur_byte = ones_char({1'b0, sec_s});
         4'd8:    cur_byte = 8'h2E;
         4'd9:    cur_byte = tens_char(cent_s);
         4'd10:   cur_byte = ones_char(cent_s);
         4'd11:   cur_byte = 8'h0D;
         4'd12:   cur_byte = 8'h0A;
         default: cur_byte = 8'h00;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         idx           <= 4'd0;
         hour_s        <= '0;
         min_s         <= '0;
         sec_s         <= '0;
         cent_s        <= '0;
         start_trigger <= 1'b0;
         tx_data       <= 8'h00;
         sender_busy   <= 1'b0;
         done          <= 1'b0;
      end else begin
         start_trigger <= 1'b0;
         done          <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (send_req) begin
                  hour_s      <= hour;
                  min_s       <= min;
                  sec_s       <= sec;
                  cent_s      <= cent;
                  idx         <= 4'd0;
                  sender_busy <= 1'b1;
                  state       <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  start_trigger <= 1'b1;
                  tx_data       <= cur_byte;
                  state         <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (tx_busy) state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (idx == LAST_IDX) begin
                     done        <= 1'b1;
                     sender_busy <= 1'b0;
                     state       <= ST_IDLE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= ST_SEND;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_time_sender.sv
// Bench for uart_time_sender: a CRLF and a no-CRLF instance, each with a small
// UART busy model, checked against a message model built from the time fields.
module tb_uart_time_sender;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       send_req0 = 1'b0, send_req1 = 1'b0;
   logic [4:0] hour = '0;
   logic [5:0] min = '0;
   logic [5:0] sec = '0;
   logic [6:0] cent = '0;
   logic       tx_busy0 = 1'b0, tx_busy1 = 1'b0;
   logic       start_trigger0, start_trigger1;
   logic [7:0] tx_data0, tx_data1;
   logic       sender_busy0, sender_busy1;
   logic       done0, done1;

   int checks = 0;
   int errors = 0;
   int trig_cnt0 = 0, trig_cnt1 = 0;
   int done_cnt0 = 0, done_cnt1 = 0;
   int busy_cnt0 = 0, busy_cnt1 = 0;
   logic force_busy0 = 1'b0;
   logic prev_trig0 = 1'b0, prev_trig1 = 1'b0;
   logic [7:0] exp_q0[$], exp_q1[$];
   logic [7:0] cap0[$], cap1[$];

   always #5 clk = ~clk;

   uart_time_sender #(.SEND_CRLF(1)) dut0 (
      .clk(clk), .rst(rst), .send_req(send_req0),
      .hour(hour), .min(min), .sec(sec), .cent(cent),
      .tx_busy(tx_busy0), .start_trigger(start_trigger0), .tx_data(tx_data0),
      .sender_busy(sender_busy0), .done(done0)
   );

   uart_time_sender #(.SEND_CRLF(0)) dut1 (
      .clk(clk), .rst(rst), .send_req(send_req1),
      .hour(hour), .min(min), .sec(sec), .cent(cent),
      .tx_busy(tx_busy1), .start_trigger(start_trigger1), .tx_data(tx_data1),
      .sender_busy(sender_busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Message model: fields in order, two decimal digits each, saturated at 99.
   function automatic logic [7:0] exp_byte(input int h, m, s, c, i);
      int f[4];
      int v;
      f = '{h, m, s, c};
      if (i == 11) return 8'h0D;
      if (i == 12) return 8'h0A;
      if (i == 8) return 8'h2E;
      if (i % 3 == 2) return 8'h3A;
      v = (f[i / 3] > 99) ? 99 : f[i / 3];
      return 8'(48 + ((i % 3 == 0) ? v / 10 : v % 10));
   endfunction

   // UART model: busy for four cycles after each start pulse.
   always @(negedge clk) begin
      if (force_busy0) tx_busy0 = 1'b1;
      else if (busy_cnt0 > 0) begin busy_cnt0--; tx_busy0 = (busy_cnt0 != 0); end
      else if (start_trigger0) begin busy_cnt0 = 4; tx_busy0 = 1'b1; end
      else tx_busy0 = 1'b0;
      if (busy_cnt1 > 0) begin busy_cnt1--; tx_busy1 = (busy_cnt1 != 0); end
      else if (start_trigger1) begin busy_cnt1 = 4; tx_busy1 = 1'b1; end
      else tx_busy1 = 1'b0;
   end

   // Compare process.
   always @(negedge clk) begin
      if (rst) begin
         if (start_trigger0) begin
            trig_cnt0++;
            cap0.push_back(tx_data0);
            check("trig_width0", prev_trig0, 0);
            if (exp_q0.size() == 0) check("unexpected_trig0", 1, 0);
            else check("byte0", tx_data0, exp_q0.pop_front());
         end
         if (start_trigger1) begin
            trig_cnt1++;
            cap1.push_back(tx_data1);
            check("trig_width1", prev_trig1, 0);
            if (exp_q1.size() == 0) check("unexpected_trig1", 1, 0);
            else check("byte1", tx_data1, exp_q1.pop_front());
         end
         if (exp_q0.size() != 0) check("busy_in_msg0", sender_busy0, 1);
         if (exp_q1.size() != 0) check("busy_in_msg1", sender_busy1, 1);
         if (done0) begin done_cnt0++; check("done_early0", exp_q0.size(), 0); end
         if (done1) begin done_cnt1++; check("done_early1", exp_q1.size(), 0); end
      end
      prev_trig0 = start_trigger0;
      prev_trig1 = start_trigger1;
   end

   task automatic issue(input int which, input int h, m, s, c);
      hour = h[4:0]; min = m[5:0]; sec = s[5:0]; cent = c[6:0];
      if (which == 0) send_req0 = 1'b1; else send_req1 = 1'b1;
      @(posedge clk);
      for (int i = 0; i < ((which == 0) ? 13 : 11); i++) begin
         if (which == 0) exp_q0.push_back(exp_byte(h, m, s, c, i));
         else exp_q1.push_back(exp_byte(h, m, s, c, i));
      end
      @(negedge clk);
      send_req0 = 1'b0;
      send_req1 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         seen = (which == 0) ? done0 : done1;
      end
      check("done_timeout", seen, 1);
   endtask

   initial begin
      int base;
      int dbase;

      // Reset state.
      #2;
      check("rst_trig", start_trigger0, 0);
      check("rst_data", tx_data0, 8'h00);
      check("rst_busy", sender_busy0, 0);
      check("rst_done", done0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Message and latency.
      cap0.delete(); base = trig_cnt0; dbase = done_cnt0;
      issue(0, 12, 34, 56, 78);
      check("latency_edge1", start_trigger0, 0);
      @(negedge clk);
      check("latency_edge2", start_trigger0, 1);
      wait_done(0, 400);
      check("msg_busy_low", sender_busy0, 0);
      repeat (5) @(negedge clk);
      check("msg_count", trig_cnt0 - base, 13);
      check("msg_done_cnt", done_cnt0 - dbase, 1);
      check("msg_b0", cap0[0], 8'h31);
      check("msg_b2", cap0[2], 8'h3A);
      check("msg_b8", cap0[8], 8'h2E);
      check("msg_b10", cap0[10], 8'h38);
      check("msg_b12", cap0[12], 8'h0A);

      // Snapshot held; requests during the message and on the done edge ignored.
      cap0.delete(); base = trig_cnt0;
      issue(0, 12, 34, 56, 78);
      repeat (10) @(negedge clk);
      hour = 5'd1; min = 6'd2; sec = 6'd3; cent = 7'd4;
      send_req0 = 1'b1;
      wait_done(0, 400);
      send_req0 = 1'b0;
      repeat (20) @(negedge clk);
      check("snap_count", trig_cnt0 - base, 13);
      check("snap_idle", sender_busy0, 0);
      check("snap_b3", cap0[3], 8'h33);

      // Boundary values, cent saturates.
      cap0.delete(); base = trig_cnt0;
      issue(0, 0, 59, 0, 127);
      wait_done(0, 400);
      check("bnd_count", trig_cnt0 - base, 13);
      check("bnd_b4", cap0[4], 8'h39);
      check("bnd_b9", cap0[9], 8'h39);
      check("bnd_b10", cap0[10], 8'h39);

      // Back-pressure: busy held before and through SEND.
      force_busy0 = 1'b1;
      @(negedge clk);
      base = trig_cnt0;
      issue(0, 7, 8, 9, 10);
      repeat (20) @(negedge clk);
      check("bp_no_trig", trig_cnt0 - base, 0);
      check("bp_busy", sender_busy0, 1);
      force_busy0 = 1'b0;
      wait_done(0, 400);
      check("bp_count", trig_cnt0 - base, 13);

      // Reset abort after five bytes, then restart from byte 0.
      base = trig_cnt0;
      issue(0, 12, 34, 56, 78);
      for (int k = 0; k < 400 && (trig_cnt0 - base) < 5; k++) @(negedge clk);
      check("abort_reach5", trig_cnt0 - base, 5);
      rst = 1'b0;
      exp_q0.delete();
      #1;
      check("abort_trig", start_trigger0, 0);
      check("abort_data", tx_data0, 8'h00);
      check("abort_busy", sender_busy0, 0);
      check("abort_done", done0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      base = trig_cnt0;
      repeat (30) @(negedge clk);
      check("abort_silent", trig_cnt0 - base, 0);
      cap0.delete();
      issue(0, 23, 45, 1, 9);
      wait_done(0, 400);
      check("restart_count", trig_cnt0 - base, 13);
      check("restart_b0", cap0[0], 8'h32);
      check("restart_b1", cap0[1], 8'h33);

      // No CR LF instance.
      cap1.delete(); base = trig_cnt1; dbase = done_cnt1;
      issue(1, 1, 2, 3, 4);
      wait_done(1, 400);
      check("ncrlf_count_at_done", trig_cnt1 - base, 11);
      repeat (10) @(negedge clk);
      check("ncrlf_count", trig_cnt1 - base, 11);
      check("ncrlf_done_cnt", done_cnt1 - dbase, 1);
      check("ncrlf_b0", cap1[0], 8'h30);
      check("ncrlf_b10", cap1[10], 8'h34);
      check("ncrlf_busy", sender_busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_time_sender.md
UART_TIME_SENDER -- requirements
Module: uart_time_sender

Interface
REQ-001 SHALL have parameter: SEND_CRLF, default 1, 1 = append CR LF to each message, 0 = omit.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: send_req  input  1  request to transmit one time message; level sampled each cycle.
REQ-005 SHALL have port: hour  input  5  hours, 0..23.
REQ-006 SHALL have port: min  input  6  minutes, 0..59.
REQ-007 SHALL have port: sec  input  6  seconds, 0..59.
REQ-008 SHALL have port: cent  input  7  hundredths, 0..99.
REQ-009 SHALL have port: tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-010 SHALL have port: start_trigger  output  1  one-cycle byte-start pulse to the UART transmitter.
REQ-011 SHALL have port: tx_data  output  8  byte to transmit; valid while start_trigger is high.
REQ-012 SHALL have port: sender_busy  output  1  high from request acceptance until message complete.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when the last byte has finished.

Function
REQ-014 SHALL transmit message "HH:MM:SS.CC" followed by 0x0D 0x0A when SEND_CRLF=1: 13 bytes, or 11 bytes when SEND_CRLF=0.
REQ-015 SHALL encode each field as two ASCII digits: tens = v/10, ones = v%10, byte = 0x30 + digit; separators are 0x3A ':' and 0x2E '.'.
REQ-016 SHALL saturate any field value above 99 to "99"; values 0..99 SHALL encode with a leading zero, e.g. 5 -> "05".
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT_ACK and WAIT_DONE.
REQ-018 In IDLE, send_req=1 SHALL latch hour/min/sec/cent into snapshot registers, clear byte index to 0, set sender_busy=1, and go to SEND.
REQ-019 In SEND with tx_busy=0, the block SHALL register start_trigger=1 and tx_data=byte[index] and go to WAIT_ACK; with tx_busy=1 it SHALL stay in SEND.
REQ-020 start_trigger SHALL be high for exactly one cycle per byte.
REQ-021 tx_data SHALL hold its value from SEND exit until the next byte is loaded.
REQ-022 In WAIT_ACK, the FSM SHALL go to WAIT_DONE on tx_busy=1, else stay.
REQ-023 In WAIT_DONE with tx_busy=0: if the index is the last byte, the block SHALL pulse done=1, clear sender_busy and go to IDLE; otherwise it SHALL increment the index and go to SEND.
REQ-024 Latency SHALL be: send_req sampled at edge N -> start_trigger high in the cycle after edge N+1 (tx_busy=0 assumed).
REQ-025 send_req outside IDLE SHALL be ignored and not queued; a request in the same cycle as done SHALL be ignored.
REQ-026 Changes to the time inputs after acceptance SHALL NOT affect the message in flight.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, start_trigger=0, tx_data=0x00, sender_busy=0, done=0, byte index 0 and snapshots 0.
REQ-029 Reset mid-message SHALL abort the message with no further start_trigger; the first request after release SHALL restart at byte 0.

Verification
REQ-030 Reset scenario: apply reset -> start_trigger=0, tx_data=0x00, sender_busy=0, done=0.
REQ-031 Message scenario: 12:34:56.78, pulse send_req, uart_tx model attached -> bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A, one done pulse, sender_busy low afterwards.
REQ-032 Snapshot and ignore scenario: change inputs and pulse send_req during the message -> original bytes only, exactly 13 start_trigger pulses.
REQ-033 Boundary scenario: hour=0, min=59, sec=0, cent=127 -> bytes 30 30 3A 35 39 3A 30 30 2E 39 39 0D 0A.
REQ-034 Reset-abort scenario: assert rst after byte 5 -> no further triggers; a new send_req then starts with byte 0x3? (tens of hour).
REQ-035 No-CRLF scenario: SEND_CRLF=0, 01:02:03.04 -> 11 bytes 30 31 3A 30 32 3A 30 33 2E 30 34, done after byte 11.
REQ-036 Back-pressure scenario: tx_busy forced high in SEND for 20 cycles -> no start_trigger until tx_busy falls.
